// File: rtl/tff_write_scheduler.sv
// Round-robin scheduler that shares one external T-flop bank between NREQ writers.
// Issues t = target ^ q, checks read-back, and retries up to MAX_RETRY times.

module tff_ws_lane #(
  parameter int WIDTH = 8
) (
  input  logic             req_i,
  input  logic             mask_i,
  input  logic             sel_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic             elig_o,
  output logic [WIDTH-1:0] data_o
);
  // A requester finishing this cycle sits out one arbitration round.
  assign elig_o = req_i & ~mask_i;
  assign data_o = sel_i ? wdata_i : '0;
endmodule

module tff_write_scheduler #(
  parameter int NREQ      = 4,
  parameter int WIDTH     = 8,
  parameter int MAX_RETRY = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] wdata,
  input  logic [WIDTH-1:0]      q_in,
  output logic [WIDTH-1:0]      t_out,
  output logic [NREQ-1:0]       gnt,
  output logic [NREQ-1:0]       done,
  output logic                  err,
  output logic                  busy
);
  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam logic [RW-1:0] MAXR    = RW'(MAX_RETRY);
  localparam logic [PW-1:0] PTR_RST = PW'(NREQ - 1);

  typedef enum logic [1:0] {IDLE, TOGGLE, CHECK} state_t;

  state_t                       state_q, state_d;
  logic [PW-1:0]                ptr_q, ptr_d;
  logic [RW-1:0]                retry_q, retry_d;
  logic [WIDTH-1:0]             data_q, data_d;
  logic [NREQ-1:0]              gnt_q, gnt_d;
  logic [NREQ-1:0]              done_q, done_d;
  logic                         err_q, err_d;

  logic [NREQ-1:0]              elig;
  logic [NREQ-1:0]              win_oh;
  logic                         win_found;
  logic [PW-1:0]                win_idx;
  logic [NREQ-1:0][WIDTH-1:0]   lane_data;
  logic [WIDTH-1:0]             win_data;

  for (genvar g = 0; g < NREQ; g++) begin : g_lane
    tff_ws_lane #(.WIDTH(WIDTH)) u_lane (
      .req_i   (req[g]),
      .mask_i  (done_q[g]),
      .sel_i   (win_oh[g]),
      .wdata_i (wdata[g*WIDTH +: WIDTH]),
      .elig_o  (elig[g]),
      .data_o  (lane_data[g])
    );
  end

  // Scan upward from the last winner so priority rotates.
  always_comb begin
    logic [PW-1:0] idx;
    win_found = 1'b0;
    win_idx   = ptr_q;
    win_oh    = '0;
    idx       = '0;
    for (int off = 1; off <= NREQ; off++) begin
      idx = PW'((int'(ptr_q) + off) % NREQ);
      if (!win_found && elig[idx]) begin
        win_found   = 1'b1;
        win_idx     = idx;
        win_oh[idx] = 1'b1;
      end
    end
  end

  always_comb begin
    win_data = '0;
    for (int i = 0; i < NREQ; i++) win_data |= lane_data[i];
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    retry_d = retry_q;
    data_d  = data_q;
    gnt_d   = gnt_q;
    done_d  = '0;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (win_found) begin
          state_d = TOGGLE;
          gnt_d   = win_oh;
          ptr_d   = win_idx;
          data_d  = win_data;
          retry_d = '0;
        end
      end
      TOGGLE: state_d = CHECK;
      CHECK: begin
        if (q_in == data_q) begin
          done_d  = gnt_q;
          gnt_d   = '0;
          state_d = IDLE;
        end else if (retry_q < MAXR) begin
          retry_d = retry_q + RW'(1);
          state_d = TOGGLE;
        end else begin
          done_d  = gnt_q;
          err_d   = 1'b1;
          gnt_d   = '0;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      ptr_q   <= PTR_RST;
      retry_q <= '0;
      data_q  <= '0;
      gnt_q   <= '0;
      done_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      retry_q <= retry_d;
      data_q  <= data_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  // Toggle enables only exist in TOGGLE so reset silences them immediately.
  assign t_out = (state_q == TOGGLE) ? (data_q ^ q_in) : '0;
  assign gnt   = gnt_q;
  assign done  = done_q;
  assign err   = err_q;
  assign busy  = (state_q != IDLE);
endmodule
